// File: rtl/contador_dezena_if.sv
// rtl/contador_dezena_if.sv - count/load/carry signal bundle between the tens-of-seconds stage and its neighbours
interface contador_dezena_if;
    logic       tick_in;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] qDezenadeSegundos;
    logic       clk2;
    logic       running;

    // Upstream side: drives the count/load controls and observes the digit, carry and mode.
    modport master (
        output tick_in,
        output load,
        output load_value,
        input  qDezenadeSegundos,
        input  clk2,
        input  running
    );

    // Counter side.
    modport slave (
        input  tick_in,
        input  load,
        input  load_value,
        output qDezenadeSegundos,
        output clk2,
        output running
    );
endinterface

// File: rtl/contador_dezena.sv
// rtl/contador_dezena.sv - tens-of-seconds BCD stage with RUN/PAUSE FSM, set button and load; optional DEBOUNCE_EN button filter
module contador_dezena #(
    parameter int MODULO          = 6,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk1,
    input  logic               clear,
    input  logic               pause_btn,
    input  logic               set_btn,
    contador_dezena_if.slave   bus
);

    typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_t;

    localparam logic [3:0] MAX_DIGIT = 4'(MODULO - 1);

    // Elaboration-time guard on the parameter ranges.
    if (MODULO < 2 || MODULO > 10 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : gBadParam
        $error("contador_dezena: parameter out of legal range");
    end

    logic [1:0] pauseSync;
    logic [1:0] setSync;
    logic       pauseLevel;
    logic       setLevel;
    logic       pausePrev;
    logic       setPrev;
    logic       pause_p;
    logic       set_p;

    state_t     state;
    state_t     nextState;
    logic [3:0] digit;
    logic [3:0] nextDigit;
    logic       carry;
    logic       nextCarry;

    // Two-flop synchronizers bring the raw buttons into the clk1 domain.
    always_ff @(posedge clk1) begin
        if (clear) begin
            pauseSync <= 2'b00;
            setSync   <= 2'b00;
        end else begin
            pauseSync <= {pauseSync[0], pause_btn};
            setSync   <= {setSync[0], set_btn};
        end
    end

`ifdef DEBOUNCE_EN
    localparam logic [7:0] DEBOUNCE_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] pauseCnt;
    logic [7:0] setCnt;
    logic       pauseFilt;
    logic       setFilt;

    // Filtered level only follows the synchronized input after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk1) begin
        if (clear) begin
            pauseCnt  <= 8'd0;
            pauseFilt <= 1'b0;
        end else if (pauseSync[1] == pauseFilt) begin
            pauseCnt  <= 8'd0;
        end else if (pauseCnt == DEBOUNCE_LAST) begin
            pauseCnt  <= 8'd0;
            pauseFilt <= pauseSync[1];
        end else begin
            pauseCnt  <= pauseCnt + 8'd1;
        end
    end

    // Same filter for the set button.
    always_ff @(posedge clk1) begin
        if (clear) begin
            setCnt  <= 8'd0;
            setFilt <= 1'b0;
        end else if (setSync[1] == setFilt) begin
            setCnt  <= 8'd0;
        end else if (setCnt == DEBOUNCE_LAST) begin
            setCnt  <= 8'd0;
            setFilt <= setSync[1];
        end else begin
            setCnt  <= setCnt + 8'd1;
        end
    end

    assign pauseLevel = pauseFilt;
    assign setLevel   = setFilt;
`else
    assign pauseLevel = pauseSync[1];
    assign setLevel   = setSync[1];
`endif

    // Previous level for rising-edge detection, so a held button acts once.
    always_ff @(posedge clk1) begin
        if (clear) begin
            pausePrev <= 1'b0;
            setPrev   <= 1'b0;
        end else begin
            pausePrev <= pauseLevel;
            setPrev   <= setLevel;
        end
    end

    assign pause_p = pauseLevel & ~pausePrev;
    assign set_p   = setLevel & ~setPrev;

    // State, digit and carry registers.
    always_ff @(posedge clk1) begin
        if (clear) begin
            state <= RUN;
            digit <= 4'd0;
            carry <= 1'b0;
        end else begin
            state <= nextState;
            digit <= nextDigit;
            carry <= nextCarry;
        end
    end

    // Next state and digit: load beats counting; the pause toggle is independent of both.
    always_comb begin
        nextState = state;
        nextDigit = digit;
        nextCarry = 1'b0;

        if (pause_p) begin
            nextState = (state == RUN) ? PAUSE : RUN;
        end

        if (bus.load) begin
            nextDigit = (bus.load_value > MAX_DIGIT) ? MAX_DIGIT : bus.load_value;
        end else if ((state == RUN && bus.tick_in) || (state == PAUSE && set_p)) begin
            if (digit >= MAX_DIGIT) begin
                nextDigit = 4'd0;
                nextCarry = (state == RUN);
            end else begin
                nextDigit = digit + 4'd1;
            end
        end
    end

    assign bus.qDezenadeSegundos = digit;
    assign bus.clk2              = carry;
    assign bus.running           = (state == RUN);

endmodule

// File: tb/tb_contador_dezena.sv
// tb/tb_contador_dezena.sv - directed self-checking bench for contador_dezena
module tb_contador_dezena;

`ifdef DEBOUNCE_EN
    localparam int HOLD    = 40;
    localparam int BTN_LAT = 18;
`else
    localparam int HOLD    = 6;
    localparam int BTN_LAT = 2;
`endif

    logic clk1 = 1'b0;
    logic clear;
    logic pause_btn;
    logic set_btn;
    int   checks = 0;
    int   fails  = 0;
    int   clk2Count = 0;

    contador_dezena_if bus();

    contador_dezena #(.MODULO(6), .DEBOUNCE_CYCLES(16)) dut (
        .clk1      (clk1),
        .clear     (clear),
        .pause_btn (pause_btn),
        .set_btn   (set_btn),
        .bus       (bus)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (bus.clk2 === 1'b1) clk2Count++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic tick();
        bus.tick_in = 1'b1;
        step(1);
        bus.tick_in = 1'b0;
    endtask

    task automatic doLoad(input logic [3:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        step(1);
        bus.load       = 1'b0;
    endtask

    task automatic press(input bit isSet);
        if (isSet) set_btn = 1'b1; else pause_btn = 1'b1;
        step(HOLD);
        set_btn   = 1'b0;
        pause_btn = 1'b0;
        step(HOLD);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step(2);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0 || bus.clk2 !== 1'b0 || bus.running !== 1'b1) begin
            fails++;
            $display("FAIL reset: digit=%0d clk2=%b running=%b expected 0 0 1", bus.qDezenadeSegundos, bus.clk2, bus.running);
        end
        clear = 1'b0;
        step(1);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0 || bus.running !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: digit=%0d running=%b expected 0 1", bus.qDezenadeSegundos, bus.running);
        end
    endtask

    task automatic test_run_count();
        int base;
        base = clk2Count;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (bus.qDezenadeSegundos !== 4'(i % 6) || bus.clk2 !== (i == 6) || bus.running !== 1'b1) begin
                fails++;
                $display("FAIL run_tick%0d: digit=%0d clk2=%b running=%b expected %0d %0d 1", i, bus.qDezenadeSegundos, bus.clk2, bus.running, i % 6, (i == 6));
            end
            step(9);
        end
        checks++;
        if (clk2Count - base !== 1) begin
            fails++;
            $display("FAIL run_carry_count: got %0d expected 1", clk2Count - base);
        end
    endtask

`ifndef DEBOUNCE_EN
    task automatic test_button_latency();
        pause_btn = 1'b1;
        step(2);
        checks++;
        if (bus.running !== 1'b1) begin
            fails++;
            $display("FAIL latency_early: running=%b expected 1", bus.running);
        end
        step(1);
        checks++;
        if (bus.running !== 1'b0) begin
            fails++;
            $display("FAIL latency_3edges: running=%b expected 0", bus.running);
        end
        step(HOLD);
        pause_btn = 1'b0;
        step(HOLD);
        checks++;
        if (bus.running !== 1'b0) begin
            fails++;
            $display("FAIL hold_once: running=%b expected 0", bus.running);
        end
        press(1'b0);
        checks++;
        if (bus.running !== 1'b1) begin
            fails++;
            $display("FAIL latency_resume: running=%b expected 1", bus.running);
        end
    endtask
`endif

    task automatic test_pause_set();
        int base;
        base = clk2Count;
        press(1'b0);
        checks++;
        if (bus.running !== 1'b0) begin
            fails++;
            $display("FAIL pause_enter: running=%b expected 0", bus.running);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            step(3);
        end
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0) begin
            fails++;
            $display("FAIL pause_ticks_ignored: digit=%0d expected 0", bus.qDezenadeSegundos);
        end
        press(1'b1);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd1) begin
            fails++;
            $display("FAIL set_first: digit=%0d expected 1", bus.qDezenadeSegundos);
        end
        press(1'b1);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd2) begin
            fails++;
            $display("FAIL set_second: digit=%0d expected 2", bus.qDezenadeSegundos);
        end
        doLoad(4'd5);
        press(1'b1);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0 || clk2Count - base !== 0) begin
            fails++;
            $display("FAIL set_wrap: digit=%0d carries=%0d expected 0 0", bus.qDezenadeSegundos, clk2Count - base);
        end
        press(1'b0);
        checks++;
        if (bus.running !== 1'b1) begin
            fails++;
            $display("FAIL pause_exit: running=%b expected 1", bus.running);
        end
    endtask

    task automatic test_load_priority();
        doLoad(4'd5);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd5) begin
            fails++;
            $display("FAIL load_plain: digit=%0d expected 5", bus.qDezenadeSegundos);
        end
        bus.load       = 1'b1;
        bus.load_value = 4'd9;
        bus.tick_in    = 1'b1;
        step(1);
        bus.load    = 1'b0;
        bus.tick_in = 1'b0;
        checks++;
        if (bus.qDezenadeSegundos !== 4'd5 || bus.clk2 !== 1'b0) begin
            fails++;
            $display("FAIL load_beats_tick: digit=%0d clk2=%b expected 5 0", bus.qDezenadeSegundos, bus.clk2);
        end
        tick();
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0 || bus.clk2 !== 1'b1) begin
            fails++;
            $display("FAIL tick_after_load: digit=%0d clk2=%b expected 0 1", bus.qDezenadeSegundos, bus.clk2);
        end
        doLoad(4'd3);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd3 || bus.clk2 !== 1'b0) begin
            fails++;
            $display("FAIL load_three: digit=%0d clk2=%b expected 3 0", bus.qDezenadeSegundos, bus.clk2);
        end
        doLoad(4'd6);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd5) begin
            fails++;
            $display("FAIL load_clamp_modulo: digit=%0d expected 5", bus.qDezenadeSegundos);
        end
    endtask

    task automatic test_tick_pause_coincident();
        doLoad(4'd5);
        pause_btn = 1'b1;
        step(BTN_LAT);
        bus.tick_in = 1'b1;
        step(1);
        bus.tick_in = 1'b0;
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0 || bus.clk2 !== 1'b1 || bus.running !== 1'b0) begin
            fails++;
            $display("FAIL tick_pause_same_edge: digit=%0d clk2=%b running=%b expected 0 1 0", bus.qDezenadeSegundos, bus.clk2, bus.running);
        end
        step(HOLD);
        pause_btn = 1'b0;
        step(HOLD);
        press(1'b0);
        checks++;
        if (bus.running !== 1'b1) begin
            fails++;
            $display("FAIL tick_pause_resume: running=%b expected 1", bus.running);
        end
    endtask

    task automatic test_clear();
        doLoad(4'd5);
        tick();
        checks++;
        if (bus.clk2 !== 1'b1) begin
            fails++;
            $display("FAIL clear_setup_wrap: clk2=%b expected 1", bus.clk2);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0 || bus.clk2 !== 1'b0 || bus.running !== 1'b1) begin
            fails++;
            $display("FAIL clear_after_wrap: digit=%0d clk2=%b running=%b expected 0 0 1", bus.qDezenadeSegundos, bus.clk2, bus.running);
        end
        press(1'b0);
        doLoad(4'd4);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checks++;
        if (bus.qDezenadeSegundos !== 4'd0 || bus.running !== 1'b1) begin
            fails++;
            $display("FAIL clear_in_pause: digit=%0d running=%b expected 0 1", bus.qDezenadeSegundos, bus.running);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expDigit [3];
        logic       expCarry [3];
        expDigit = '{4'd5, 4'd0, 4'd1};
        expCarry = '{1'b0, 1'b1, 1'b0};
        doLoad(4'd4);
        bus.tick_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (bus.qDezenadeSegundos !== expDigit[i] || bus.clk2 !== expCarry[i]) begin
                fails++;
                $display("FAIL back_to_back%0d: digit=%0d clk2=%b expected %0d %b", i, bus.qDezenadeSegundos, bus.clk2, expDigit[i], expCarry[i]);
            end
        end
        bus.tick_in = 1'b0;
        step(1);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd1 || bus.clk2 !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back_idle: digit=%0d clk2=%b expected 1 0", bus.qDezenadeSegundos, bus.clk2);
        end
    endtask

`ifdef DEBOUNCE_EN
    task automatic test_debounce();
        doLoad(4'd2);
        press(1'b0);
        set_btn = 1'b1;
        step(10);
        set_btn = 1'b0;
        step(40);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd2) begin
            fails++;
            $display("FAIL debounce_glitch: digit=%0d expected 2", bus.qDezenadeSegundos);
        end
        set_btn = 1'b1;
        step(40);
        set_btn = 1'b0;
        step(40);
        checks++;
        if (bus.qDezenadeSegundos !== 4'd3) begin
            fails++;
            $display("FAIL debounce_press: digit=%0d expected 3", bus.qDezenadeSegundos);
        end
        press(1'b0);
    endtask
`endif

    initial begin
        clear          = 1'b1;
        pause_btn      = 1'b0;
        set_btn        = 1'b0;
        bus.tick_in    = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = 4'd0;
        #1;
        test_reset();
        test_run_count();
`ifndef DEBOUNCE_EN
        test_button_latency();
`endif
        test_pause_set();
        test_load_priority();
        test_tick_pause_coincident();
        test_clear();
        test_back_to_back();
`ifdef DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/contador_dezena.md
# contador_dezena

Tens-of-seconds stage of the chronometer chain, directly downstream of the units-of-seconds counter. Consumes the units stage's wrap pulse and counts one BCD digit from 0 to MODULO-1 (default 0–5). Emits a one-cycle carry pulse to the minutes stage on each wrap. Adds a RUN/PAUSE mode FSM with a set button for manual digit adjustment and a synchronous parallel load.

## Interface
- MODULO, 6, digit count range 0..MODULO-1; legal 2..10
- DEBOUNCE_CYCLES, 16, stable-sample count for button filtering; used only when DEBOUNCE_EN is defined; legal 2..255
- clk1  input  1  system clock, all logic on rising edge
- clear  input  1  reset, synchronous, active-high
- tick_in  input  1  one-cycle wrap pulse from the units stage (units 9->0)
- pause_btn  input  1  raw asynchronous button; each press toggles RUN/PAUSE
- set_btn  input  1  raw asynchronous button; each press increments the digit while in PAUSE
- load  input  1  synchronous load strobe
- load_value  input  4  value written on load
- qDezenadeSegundos  output  4  current BCD digit
- clk2  output  1  registered one-cycle carry pulse to the minutes stage
- running  output  1  1 in RUN, 0 in PAUSE

## Operation
**Button conditioning**
- Each button passes through a 2-flop synchronizer, then a rising-edge detector.
- The detector produces a one-cycle internal pulse (pause_p, set_p).

**FSM**
- Two states: RUN and PAUSE. Reset state is RUN.
- pause_p toggles the state: RUN->PAUSE or PAUSE->RUN.

**Counting**
- RUN: tick_in increments the digit. At MODULO-1, the next tick wraps the digit to 0 and asserts clk2.
- RUN: set_p is ignored.
- PAUSE: tick_in is ignored.
- PAUSE: set_p increments the digit with the same wrap, but clk2 is never asserted.

**Load**
- Accepted in either state. load_value is written to the digit.
- Values >= MODULO are clamped to MODULO-1.
- Load never asserts clk2 and does not change state.

**Priority, highest first**
- clear
- load
- tick_in/set_p digit update
- The pause_p state toggle is evaluated independently on the same edge.
- Consequence: a tick arriving in RUN on the same cycle as pause_p is counted (including any carry), then the state becomes PAUSE.
- Load and tick_in on the same cycle: load wins; the tick is dropped and no carry is generated.

**Arithmetic**
- The digit is a 4-bit unsigned register.
- Increment is a compare against MODULO-1, then reset to 0. No binary overflow path.

## Timing
- Reset values: qDezenadeSegundos=0, clk2=0, running=1, synchronizer/edge flops=0, debounce counters=0.
- tick_in sampled on edge N: the new digit is visible after edge N. clk2 (for a wrap) is high for exactly the cycle after edge N, aligned with the digit reading 0.
- Button latency without DEBOUNCE_EN: a press is visible as a state or digit change 3 edges after the raw input rises (2 synchronizer flops plus 1 edge detect/update).
- Holding a button produces exactly one action. Release produces none.
- Back-to-back tick_in on consecutive cycles: each is counted. A wrap followed by another tick gives clk2 high for one cycle only.
- clear mid-operation: all state returns to reset values on that edge. A clk2 pulse in flight is cancelled.
- Only clk2 and qDezenadeSegundos feed downstream. Both are registered outputs.

## Configuration
- Macro DEBOUNCE_EN.
- Defined: after synchronization, each button has a counter that must see DEBOUNCE_CYCLES consecutive equal samples before the filtered level changes. Edge detection acts on the filtered level. Added latency is DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no action.
- Undefined: the counters are absent, and edge detection acts on the synchronizer output directly.

## Test plan
- Reset, then 6 tick_in pulses 10 cycles apart (MODULO=6) -> digit steps 1,2,3,4,5,0; clk2 high exactly one cycle, coincident with digit=0; running=1 throughout.
- pause_btn press, then 3 tick_in pulses and 2 set_btn presses -> running=0, ticks ignored, digit 0->2, clk2 never asserted; second pause_btn press returns running=1.
- Digit=5 in RUN with load=1, load_value=9, and tick_in on the same cycle -> digit=5 (clamped), clk2=0; next tick -> digit=0, clk2 pulse.
- Digit=5, tick_in and pause_p coincident -> digit=0, clk2 pulse, running=0 on the following cycle.
- clear asserted on the cycle after a wrap (clk2 high) -> next cycle digit=0, clk2=0, running=1.
- With DEBOUNCE_EN, DEBOUNCE_CYCLES=16: a 10-cycle set_btn glitch in PAUSE -> no change; a 40-cycle press -> digit +1 exactly once.
